dataproc_job_scheduler: RTL and testbench

- Sequences the pixel producer/processor datapath through a queue of processing jobs.
- Each job carries a processing mode and a pixel count. The scheduler holds jobs in a small FIFO and configures the processor's mode and start inputs.
- Per job, it gates the producer until exactly job_len input beats are accepted, then waits for job_len output beats before retiring the job.
- Sits between the CPU register block (job push side) and the data_prod/data_proc pair (control side).

---
 rtl/dataproc_job_scheduler.sv | 136 +++++++++++++
 tb/tb_dataproc_job_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataproc_job_scheduler.sv
// Job scheduler for the pixel producer/processor pair: queues {mode,len} jobs and
// sequences each one through setup, input gating, output drain and retire.
module dataproc_job_scheduler #(
    parameter int JOB_DEPTH = 4,
    parameter int LEN_W     = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [1:0]                   job_mode,
    input  logic [LEN_W-1:0]             job_len,
    input  logic                         abort,
    input  logic                         err_clear,
    input  logic                         in_valid,
    input  logic                         in_ready,
    input  logic                         out_valid,
    input  logic                         out_ready,
    output logic                         prod_enable,
    output logic                         proc_start,
    output logic [1:0]                   proc_mode,
    output logic                         busy,
    output logic                         job_done,
    output logic [LEN_W-1:0]             done_count,
    output logic                         err_timeout,
    output logic [$clog2(JOB_DEPTH):0]   fifo_level
);
    localparam int PW   = $clog2(JOB_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]       fifo_mode [JOB_DEPTH];
    logic [LEN_W-1:0] fifo_len  [JOB_DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [LEN_W-1:0] cur_len, in_cnt, out_cnt, out_cnt_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic             active, in_beat, out_beat, wd_fire;

    assign fifo_level  = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (fifo_level == (PW+1)'(JOB_DEPTH));
    assign job_ready   = !full && !abort;
    assign push        = job_valid && job_ready;
    assign pop         = (state == IDLE) && !empty && !err_timeout && !abort;
    assign busy        = (state != IDLE);

    // Beats derived from state directly so the FSM block has no feedback on its own outputs.
    assign active      = (state == RUN) || (state == DRAIN);
    assign in_beat     = in_valid && in_ready && (state == RUN);
    assign out_beat    = out_valid && out_ready;
    assign out_cnt_nxt = out_cnt + {{(LEN_W-1){1'b0}}, out_beat};
    assign wd_fire     = active && !out_beat && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt   = state;
        proc_start  = 1'b0;
        prod_enable = 1'b0;
        job_done    = 1'b0;
        unique case (state)
            IDLE:  if (pop) state_nxt = SETUP;
            SETUP: state_nxt = (cur_len == '0) ? DONE : RUN;
            RUN: begin
                proc_start  = 1'b1;
                prod_enable = 1'b1;
                if (wd_fire)
                    state_nxt = IDLE;
                else if (in_beat && (in_cnt + LEN_W'(1) == cur_len))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                proc_start = 1'b1;
                if (wd_fire)
                    state_nxt = IDLE;
                else if (out_cnt_nxt == cur_len)
                    state_nxt = DONE;
            end
            DONE: begin
                job_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Job payload storage needs no reset; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_ptr[PW-1:0]] <= job_mode;
            fifo_len[wr_ptr[PW-1:0]]  <= job_len;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            proc_mode   <= '0;
            cur_len     <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wd_cnt      <= '0;
            done_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (abort)    rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);

            // Mode lands during SETUP, a full cycle ahead of proc_start.
            if (pop) begin
                proc_mode <= fifo_mode[rd_ptr[PW-1:0]];
                cur_len   <= fifo_len[rd_ptr[PW-1:0]];
                in_cnt    <= '0;
                out_cnt   <= '0;
            end else begin
                if (in_beat)           in_cnt  <= in_cnt + LEN_W'(1);
                if (active && out_beat) out_cnt <= out_cnt_nxt;
            end

            if (state == SETUP) wd_cnt <= '0;
            else if (active)    wd_cnt <= out_beat ? '0 : wd_cnt + WD_W'(1);

            if (state == DONE) done_count <= done_count + LEN_W'(1);

            if (wd_fire && !abort) err_timeout <= 1'b1;
            else if (err_clear)    err_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dataproc_job_scheduler.sv
// Randomized bench for dataproc_job_scheduler: a job-level timeline model predicts
// every control output each cycle while a bench-side processor produces the beats.
module tb_dataproc_job_scheduler;
    localparam int DEPTH = 4;
    localparam int LEN_W = 16;
    localparam int TMO   = 64;
    localparam int INF   = 32'h7fffffff;

    logic clk = 1'b0, resetn = 1'b1;
    logic job_valid = 1'b0, abort = 1'b0, err_clear = 1'b0;
    logic [1:0] job_mode = '0;
    logic [LEN_W-1:0] job_len = '0;
    logic in_valid = 1'b0, in_ready = 1'b0, out_valid = 1'b0, out_ready = 1'b0;
    logic job_ready, prod_enable, proc_start, busy, job_done, err_timeout;
    logic [1:0] proc_mode;
    logic [LEN_W-1:0] done_count;
    logic [2:0] fifo_level;

    int n_tests = 0, n_fail = 0;

    dataproc_job_scheduler #(.JOB_DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .job_valid(job_valid), .job_ready(job_ready),
        .job_mode(job_mode), .job_len(job_len), .abort(abort), .err_clear(err_clear),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .prod_enable(prod_enable), .proc_start(proc_start), .proc_mode(proc_mode),
        .busy(busy), .job_done(job_done), .done_count(done_count),
        .err_timeout(err_timeout), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Processor stand-in: each accepted input yields one output a few cycles later;
    // it restarts (drops pending work) whenever proc_start is low.
    int pend = 0;
    logic [2:0] dly = '0;
    logic in_beat_q = 1'b0, out_beat_q = 1'b0, out_block = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!resetn || !proc_start) begin
            pend = 0;
            dly  = '0;
        end else begin
            if (out_beat_q && pend > 0) pend--;
            pend += int'(dly[2]);
            dly = {dly[1:0], in_beat_q};
        end
        in_valid  = ($urandom_range(0, 3) != 0);
        in_ready  = ($urandom_range(0, 3) != 0);
        out_valid = proc_start && !out_block && (pend > 0) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 4) != 0);
    end

    // Job-level model: each job is a timeline (start, done, end cycles) plus beat tallies.
    typedef struct { logic [1:0] mode; int len; } job_t;
    job_t mq[$];
    job_t jf;
    int cyc = 0, s_cyc = 0, d_cyc = INF, e_cyc = INF, icnt = 0, ocnt = 0, wd = 0, m_done = 0;
    bit act = 0, m_err = 0, tmo, ib, ob, push_ok, b_exp, st_exp, pe_exp;
    logic [1:0] j_mode = '0;
    int j_len = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            mq.delete();
            act = 0; m_err = 0; m_done = 0; cyc = 0;
            in_beat_q = 1'b0; out_beat_q = 1'b0;
        end else begin
            cyc++;
            if (act && cyc >= e_cyc) act = 0;
            b_exp  = act && (cyc >= s_cyc);
            st_exp = b_exp && (cyc > s_cyc) && (cyc < d_cyc);
            pe_exp = st_exp && (icnt < j_len);
            chk("busy", busy, b_exp);
            chk("proc_start", proc_start, st_exp);
            chk("prod_enable", prod_enable, pe_exp);
            chk("job_done", job_done, b_exp && (cyc == d_cyc));
            chk("job_ready", job_ready, (mq.size() < DEPTH) && !abort);
            chk("fifo_level", fifo_level, mq.size());
            chk("err_timeout", err_timeout, m_err);
            chk("done_count", done_count, m_done % 65536);
            if (b_exp) chk("proc_mode", proc_mode, j_mode);

            in_beat_q  = in_valid && in_ready && prod_enable;
            out_beat_q = out_valid && out_ready;
            ib      = in_valid && in_ready && pe_exp;
            ob      = out_valid && out_ready && st_exp;
            push_ok = job_valid && !abort && (mq.size() < DEPTH);
            tmo     = 0;
            if (b_exp && cyc == d_cyc) m_done++;
            if (abort) begin
                mq.delete();
                if (act) e_cyc = cyc + 1;
            end else begin
                if (st_exp) begin
                    icnt += int'(ib);
                    if (ob) begin ocnt++; wd = 0; end
                    else wd++;
                    if (wd == TMO) begin
                        tmo = 1;
                        e_cyc = cyc + 1;
                    end else if (icnt == j_len && ocnt == j_len) begin
                        d_cyc = cyc + 1;
                        e_cyc = cyc + 2;
                    end
                end
                if (!act && mq.size() > 0 && !m_err) begin
                    jf = mq.pop_front();
                    j_mode = jf.mode; j_len = jf.len;
                    act = 1; s_cyc = cyc + 1; icnt = 0; ocnt = 0; wd = 0;
                    d_cyc = (j_len == 0) ? s_cyc + 1 : INF;
                    e_cyc = (j_len == 0) ? s_cyc + 2 : INF;
                end
                if (push_ok) mq.push_back('{job_mode, int'(job_len)});
            end
            if (err_clear) m_err = 0;
            if (tmo) m_err = 1;
        end
    end

    task automatic push_job(input int m, input int l);
        int k;
        @(posedge clk); #1;
        job_valid = 1'b1; job_mode = 2'(m); job_len = LEN_W'(l);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (job_ready) break;
        end
        if (k == 200) chk("push_ready", job_ready, 1);
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        if (k == 400) chk(tag, busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && fifo_level == 0) break;
        end
        if (k == 3000) chk(tag, int'(busy) + int'(fifo_level), 0);
    endtask

    initial begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_job_ready", job_ready, 1);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_proc_start", proc_start, 0);
        chk("rst_prod_enable", prod_enable, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_proc_mode", proc_mode, 0);
        chk("rst_job_done", job_done, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // single job: mode visible in SETUP before start rises
        push_job(1, 8);
        wait_busy("j1_start");
        chk("setup_mode", proc_mode, 1);
        chk("setup_start", proc_start, 0);
        @(negedge clk);
        chk("run_start", proc_start, 1);
        wait_idle("j1_idle");
        chk("j1_done_count", done_count, 1);

        // fill the queue behind a stalled job
        out_block = 1'b1;
        push_job(2, 4);
        wait_busy("fill_start");
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            job_valid = 1'b1; job_mode = 2'(i); job_len = LEN_W'(3 + i);
            @(posedge clk); #1;
        end
        job_valid = 1'b0;
        @(negedge clk);
        chk("fill_level", fifo_level, 4);
        chk("fill_ready", job_ready, 0);
        out_block = 1'b0;
        wait_idle("fill_idle");
        chk("fill_done_count", done_count, 6);

        // zero-length job followed by a short one
        push_job(3, 0);
        push_job(0, 2);
        wait_idle("zero_idle");
        chk("zero_done_count", done_count, 8);

        // watchdog: outputs withheld, a second job stays queued until err_clear
        out_block = 1'b1;
        push_job(1, 16);
        push_job(2, 5);
        for (int k = 0; k < 300 && !err_timeout; k++) @(negedge clk);
        chk("tmo_err", err_timeout, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_start", proc_start, 0);
        chk("tmo_level", fifo_level, 1);
        repeat (10) @(negedge clk);
        chk("tmo_stall_level", fifo_level, 1);
        chk("tmo_stall_busy", busy, 0);
        out_block = 1'b0;
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        wait_idle("tmo_idle");
        chk("tmo_done_count", done_count, 9);
        chk("tmo_cleared", err_timeout, 0);

        // abort with two jobs queued
        out_block = 1'b1;
        push_job(0, 10);
        wait_busy("abort_start");
        push_job(1, 3);
        push_job(2, 3);
        @(negedge clk);
        chk("abort_pre_level", fifo_level, 2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_start", proc_start, 0);
        chk("abort_done", job_done, 0);
        chk("abort_done_count", done_count, 9);
        out_block = 1'b0;

        // random traffic with occasional aborts, output stalls and error clears
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            job_valid = ($urandom_range(0, 3) == 0);
            job_mode  = 2'($urandom_range(0, 3));
            job_len   = LEN_W'($urandom_range(0, 12));
            abort     = ($urandom_range(0, 299) == 0);
            err_clear = ($urandom_range(0, 49) == 0);
            out_block = ((c % 1000) > 880);
        end
        job_valid = 1'b0; abort = 1'b0; out_block = 1'b0;
        err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        wait_idle("rand_idle");

        // asynchronous reset while draining
        out_block = 1'b1;
        push_job(2, 6);
        for (int k = 0; k < 300 && !(proc_start && !prod_enable); k++) @(negedge clk);
        chk("pre_rst_drain", int'(proc_start && !prod_enable), 1);
        @(posedge clk); #3 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", proc_start, 0);
        chk("arst_prod", prod_enable, 0);
        chk("arst_ready", job_ready, 1);
        chk("arst_done_count", done_count, 0);
        chk("arst_level", fifo_level, 0);
        out_block = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", job_ready, 1);
        chk("post_rst_done_count", done_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
